moore_seq_det: RTL
==================

Name: moore_seq_det

Overview:
- Parametrised Moore sequence detector; successor to the fixed 4-bit 1101 non-overlapping detector.
- Pattern width, pattern value and overlap mode are elaboration-time parameters.
- Adds an input-valid qualifier and an optional saturating hit counter.
- Sits on a serial bit stream in the same clock domain and flags each completed pattern occurrence.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1101, pattern value; MSB is the first bit received.
- OVERLAP, 0, 0 = non-overlapping detection, 1 = overlapping detection.
- CNT_W, 8, width of the hit counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in  input  1  serial data bit.
- in_valid  input  1  in is sampled only on edges where in_valid=1.
- cnt_clr  input  1  synchronous clear of det_cnt.
- out  output  1  Moore detect flag; high while the FSM is in state DETECT.
- det_cnt  output  CNT_W  number of detections, saturating.

Behaviour:
- Reset: reset_n low asynchronously forces state=S0, out=0 and det_cnt=0, regardless of clk; this includes mid-sequence. First sampling edge is the first rising clk with reset_n high.
- State register: $clog2(PAT_W+1) bits.
  - Sk (k=0..PAT_W-1) means k leading pattern bits are matched.
  - DETECT (= index PAT_W) means the full pattern is matched.
  - Encodings above PAT_W go to S0 on the next edge.
- out is decoded from the state register only; there is no combinational path from in to out.
- Latency: out rises in the cycle after the edge that samples the last pattern bit, and stays high exactly one valid cycle.
- in_valid=0: state holds, out holds (DETECT may persist across stalls), det_cnt does not increment.
- Transition from Sk with in_valid=1:
  - If in equals PATTERN[PAT_W-1-k], go to S(k+1).
  - Otherwise go to S(j), where j is the longest proper suffix of (matched prefix, in) that is also a pattern prefix (KMP fallback). Never drop straight to S0 when a partial match survives.
- Transition from DETECT with in_valid=1:
  - OVERLAP=0: treated as transition from S0.
  - OVERLAP=1: treated as transition from S(B), where B is the longest proper border of PATTERN.
  - For 1101, B=1.
- Next-state table is computed at elaboration by a constant function. No runtime pattern load.
- det_cnt:
  - Increments by 1 on every edge that enters DETECT; consecutive detections in overlap mode each count.
  - Saturates at all-ones.
  - cnt_clr=1 sets det_cnt=0 on that edge; if cnt_clr and a detection coincide, clear wins and the result is 0.

Optional Feature:
- Macro SEQ_DET_CNT_EN.
- Defined: det_cnt counter logic and cnt_clr are active as described above.
- Undefined: det_cnt is tied to 0, cnt_clr is ignored, and no counter flops are built. Port list is unchanged.

Decomposition:
- Package seq_det_pkg holds:
  - the state-index width function;
  - the constant functions next_state(k, bit, PATTERN, PAT_W) and border(PATTERN, PAT_W);
  - the DETECT index constant.
- One sub-module, seq_det_hit_cnt: saturating counter with clear, instantiated under SEQ_DET_CNT_EN.
- Top holds the FSM.

Test Plan:
- Defaults, OVERLAP=0, in_valid=1, stream 1,1,0,1,1,0,1 → out high only the cycle after bit 4; det_cnt=1.
- Defaults, OVERLAP=1, same stream → out high after bit 4 and after bit 7; det_cnt=2.
- Defaults, stream 1,1,1,0,1 → fallback S2 stays S2 on the extra 1; out high after bit 5.
- Stream 1,1,0 then in_valid=0 for 3 cycles with in toggling, then 1 → still detects; after detection, in_valid=0 keeps out=1 until the next valid bit.
- reset_n pulsed low between bits 3 and 4 of 1101 → out=0 and state S0 immediately; the following 1 does not detect.
- With SEQ_DET_CNT_EN, CNT_W=2, overlap 1101 repeated 5 times → det_cnt saturates at 3.
- With SEQ_DET_CNT_EN, cnt_clr asserted on a detection edge → det_cnt=0.
- Without SEQ_DET_CNT_EN, same stimulus → det_cnt stays 0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared elaboration-time helpers for the parametrised Moore sequence detector.
// All functions are evaluated as constants when the next-state table is built;
// none of them end up as runtime logic.
package seq_det_pkg;

    // Longest pattern the helpers support. Patterns are zero-extended to this width.
    localparam int MAX_PAT_W = 16;

    // DETECT state index for the default 4-bit pattern.
    localparam int DEF_DETECT_IDX = 4;

    // Number of bits needed to encode states S0..S(PAT_W-1) plus DETECT.
    function automatic int state_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // DETECT sits one index past the last partial-match state.
    function automatic int detect_idx(input int pat_w);
        return pat_w;
    endfunction

    // KMP-style successor of state Sk on input bit b.
    // The matched prefix (k bits) is followed by b. The result is the longest
    // suffix of that string that is also a pattern prefix. k must be < pat_w.
    function automatic int next_state(input int k, input logic b,
                                      input logic [MAX_PAT_W-1:0] pat, input int pat_w);
        logic [MAX_PAT_W:0] s;
        int                 res;
        bit                 ok;
        s   = '0;
        res = 0;
        // s[i] is the i-th received bit, oldest first
        for (int i = 0; i < MAX_PAT_W; i++)
            if (i < k) s[i] = pat[pat_w-1-i];
        s[k] = b;
        // ascending scan keeps the longest matching length
        for (int j = 1; j <= MAX_PAT_W; j++) begin
            if (j <= k + 1 && j <= pat_w) begin
                ok = 1'b1;
                for (int m = 0; m < MAX_PAT_W; m++)
                    if (m < j && s[k+1-j+m] != pat[pat_w-1-m]) ok = 1'b0;
                if (ok) res = j;
            end
        end
        return res;
    endfunction

    // Longest proper border: longest j < pat_w whose j-bit prefix equals its j-bit suffix.
    function automatic int border(input logic [MAX_PAT_W-1:0] pat, input int pat_w);
        int res;
        bit ok;
        res = 0;
        for (int j = 1; j < MAX_PAT_W; j++) begin
            if (j < pat_w) begin
                ok = 1'b1;
                for (int m = 0; m < MAX_PAT_W; m++)
                    if (m < j && pat[pat_w-1-m] != pat[j-1-m]) ok = 1'b0;
                if (ok) res = j;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_det_hit_cnt.sv
// Saturating detection counter with synchronous clear (clear beats increment).
module seq_det_hit_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // next count: clear first, then increment unless already all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/moore_seq_det.sv
// Parametrised Moore sequence detector on a qualified serial bit stream.
// State Sk = k leading pattern bits matched; index PAT_W is DETECT, which
// drives out. Mismatches fall back KMP-style to the longest surviving prefix.
// Leaving DETECT restarts from S0 (OVERLAP=0) or from the pattern border (OVERLAP=1).
// The next-state table is built from constant functions at elaboration.
// Supported PAT_W range is 2..16.
// Optional macro SEQ_DET_CNT_EN: builds the saturating hit counter behind det_cnt;
// without it det_cnt reads 0 and cnt_clr is ignored.
module moore_seq_det
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int               OVERLAP = 0,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] det_cnt
);

    localparam int                     SW      = state_w(PAT_W);
    localparam logic [MAX_PAT_W-1:0]   PAT_EXT = MAX_PAT_W'(PATTERN);
    localparam int                     BORDER  = border(PAT_EXT, PAT_W);
    localparam logic [SW-1:0]          DET     = SW'(detect_idx(PAT_W));

    // ns_tab[state][bit] -> successor state; the DETECT row folds in the overlap choice
    logic [PAT_W:0][1:0][SW-1:0] ns_tab;

    for (genvar gk = 0; gk <= PAT_W; gk++) begin : g_row
        for (genvar gb = 0; gb < 2; gb++) begin : g_bit
            localparam int KEFF = (gk == PAT_W) ? ((OVERLAP != 0) ? BORDER : 0) : gk;
            localparam int NS   = next_state(KEFF, 1'(gb), PAT_EXT, PAT_W);
            assign ns_tab[gk][gb] = SW'(NS);
        end
    end

    logic [SW-1:0] state_q, state_d;
    logic          hit;

    // next state: illegal codes recover to S0, stalls hold, valid bits walk the table
    always_comb begin
        state_d = state_q;
        hit     = 1'b0;
        if (state_q > DET) begin
            state_d = '0;
        end else if (in_valid) begin
            state_d = ns_tab[state_q][in];
            hit     = (ns_tab[state_q][in] == DET);
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= '0;
        else          state_q <= state_d;
    end

    // Moore output: pure decode of the state register
    assign out = (state_q == DET);

`ifdef SEQ_DET_CNT_EN
    seq_det_hit_cnt #(
        .CNT_W (CNT_W)
    ) u_hit_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (hit),
        .cnt     (det_cnt)
    );
`else
    // counter not built: det_cnt is constant and the clear/hit strobes go nowhere
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = cnt_clr ^ hit;
    assign det_cnt           = '0;
`endif

endmodule
